// File: rtl/seq_divider_param.sv
// Sequential restoring divider (DIV/MOD slow path) with a ripple add/sub core; optional signed mode via SEQ_DIV_SIGNED_EN.
// Latency: done is high size cycles after the accept edge; divide-by-zero completes in the cycle right after accept.
// Backpressure: none; start is only honoured in IDLE/DONE, ignored while busy, and requests are never queued.

// Ripple-carry adder/subtractor: select=1 inverts b, so with c_in=1 it computes a-b and c_out=1 means no borrow.
module adder_subtractor_param #(
  parameter int size = 8
) (
  input  logic [size-1:0] i_a,
  input  logic [size-1:0] i_b,
  input  logic            i_select,
  input  logic            i_c_in,
  output logic [size-1:0] o_sum,
  output logic            o_c_out
);

  logic [size:0]   w_carry;
  logic [size-1:0] w_b_eff;

  assign w_carry[0] = i_c_in;

  genvar gi;
  generate
    for (gi = 0; gi < size; gi++) begin : g_bit
      assign w_b_eff[gi]    = i_b[gi] ^ i_select;
      assign o_sum[gi]      = i_a[gi] ^ w_b_eff[gi] ^ w_carry[gi];
      assign w_carry[gi+1]  = (i_a[gi] & w_b_eff[gi]) | (i_a[gi] & w_carry[gi]) |
                              (w_b_eff[gi] & w_carry[gi]);
    end
  endgenerate

  assign o_c_out = w_carry[size];

endmodule

module seq_divider_param #(
  parameter int size = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
`ifdef SEQ_DIV_SIGNED_EN
  input  logic            signed_op,
`endif
  input  logic [size-1:0] dividend,
  input  logic [size-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [size-1:0] quotient,
  output logic [size-1:0] remainder,
  output logic            div_by_zero
);

  localparam int CW = $clog2(size);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [CW-1:0]   r_cnt;
  logic [size:0]   r_p;        // partial remainder, one guard bit wide
  logic [size-1:0] r_q;        // dividend bits shifting out / quotient bits shifting in
  logic [size-1:0] r_dvs;      // captured divisor magnitude
  logic            r_neg_q;    // negate quotient at completion
  logic            r_neg_r;    // negate remainder at completion
  logic [size-1:0] r_quo;
  logic [size-1:0] r_rem;
  logic            r_dbz;

  logic            w_sop;
  logic            w_accept;
  logic            w_last;
  logic            w_dvs_zero;
  logic            w_dvd_neg;
  logic            w_dvs_neg;
  logic [size-1:0] w_dvd_mag;
  logic [size-1:0] w_dvs_mag;
  logic [size:0]   w_p_shift;
  logic [size:0]   w_t;
  logic            w_c_out;
  logic [size:0]   w_p_nxt;
  logic [size-1:0] w_q_nxt;
  logic [size-1:0] w_rem_mag;
  logic [size-1:0] w_quo_fix;
  logic [size-1:0] w_rem_fix;

`ifdef SEQ_DIV_SIGNED_EN
  assign w_sop = signed_op;
`else
  assign w_sop = 1'b0;
`endif

  assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last     = (r_state == S_RUN) && (r_cnt == CW'(size - 1));
  assign w_dvs_zero = (divisor == '0);

  // Signed operands are reduced to magnitudes; -2^(size-1) maps to itself, which is correct as unsigned.
  assign w_dvd_neg = w_sop & dividend[size-1];
  assign w_dvs_neg = w_sop & divisor[size-1];
  assign w_dvd_mag = w_dvd_neg ? ((~dividend) + 1'b1) : dividend;
  assign w_dvs_mag = w_dvs_neg ? ((~divisor) + 1'b1) : divisor;

  // One restoring step: shift next dividend bit into P, trial-subtract the divisor.
  assign w_p_shift = {r_p[size-1:0], r_q[size-1]};

  adder_subtractor_param #(
    .size (size + 1)
  ) u_sub (
    .i_a      (w_p_shift),
    .i_b      ({1'b0, r_dvs}),
    .i_select (1'b1),
    .i_c_in   (1'b1),
    .o_sum    (w_t),
    .o_c_out  (w_c_out)
  );

  assign w_p_nxt   = w_c_out ? w_t : w_p_shift;
  assign w_q_nxt   = {r_q[size-2:0], w_c_out};
  assign w_rem_mag = w_p_nxt[size-1:0];

  // Sign fix-up folds into the completion edge so signed mode costs no extra cycle.
  assign w_quo_fix = r_neg_q ? ((~w_q_nxt) + 1'b1) : w_q_nxt;
  assign w_rem_fix = r_neg_r ? ((~w_rem_mag) + 1'b1) : w_rem_mag;

  // Next-state logic: zero divisor bypasses RUN; DONE can re-accept so back-to-back requests keep their done pulse.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_dvs_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        if (w_accept) begin
          w_state_nxt = w_dvs_zero ? S_DONE : S_RUN;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; reset wins over everything, including an in-flight division.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath: capture on accept, iterate in RUN, publish results only on a completion edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_p     <= '0;
      r_q     <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_p     <= '0;
      r_q     <= w_dvd_mag;
      r_dvs   <= w_dvs_mag;
      r_neg_q <= w_dvd_neg ^ w_dvs_neg;
      r_neg_r <= w_dvd_neg;
      if (w_dvs_zero) begin
        r_quo <= '1;
        r_rem <= dividend;
        r_dbz <= 1'b1;
      end
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + 1'b1;
      r_p   <= w_p_nxt;
      r_q   <= w_q_nxt;
      if (w_last) begin
        r_quo <= w_quo_fix;
        r_rem <= w_rem_fix;
        r_dbz <= 1'b0;
      end
    end
  end

  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign quotient    = r_quo;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule

// File: doc/seq_divider_param.md
Name: seq_divider_param

Overview:
- Multi-cycle unsigned restoring divider; performs the inverse operation of the team's parameterized ripple adder/subtractor.
- Computes one quotient bit per clock using a single internal (size+1)-bit adder_subtractor_param instance fixed in subtract mode (select=1, c_in=1).
- Sits beside the combinational add/sub in the ALU as the slow-path DIV/MOD unit, with a start/done handshake toward the ALU control.

Parameters:
size, 8, operand/quotient/remainder width in bits (>=2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, synchronous, active-high
start  input  1  request; sampled only when accepting (IDLE or DONE)
dividend  input  size  numerator, captured on accept edge
divisor  input  size  denominator, captured on accept edge
busy  output  1  high while state=RUN
done  output  1  one-cycle pulse, results valid
quotient  output  size  result, held until next completion
remainder  output  size  result, held until next completion
div_by_zero  output  1  set with done when captured divisor==0; held with results

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). rst takes priority over every other event.
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, state=IDLE, iteration counter=0.
- States and transitions:
  - IDLE: waiting for a request.
  - RUN: iterating.
  - DONE: lasts exactly one cycle, done=1. Next state is IDLE, or RUN if a new start is accepted.
- Accept: on edge E0 with start=1 and state in {IDLE, DONE}, capture the operands, clear the partial remainder P (size+1 bits) and the counter, and go to RUN.
- start while in RUN is ignored. No queuing; operand changes during RUN have no effect.
- Iteration (each edge in RUN):
  - Shift {P, Q} left by 1, inserting the next dividend MSB into P[0].
  - Compute T = P_shifted - {1'b0, divisor} via the adder/subtractor. Its c_out=1 means no borrow.
  - If c_out=1: P=T and the new Q LSB=1. Otherwise restore P and the new Q LSB=0.
- Counter runs 0..size-1. On the edge completing iteration size (edge E_size), load quotient=Q and remainder=P[size-1:0], clear div_by_zero, and go to DONE.
- Latency: done is high in the cycle after E_size, i.e. size cycles after the accept edge. The busy→done transition is gapless.
- Divide by zero (divisor==0 at accept):
  - Skip RUN and go straight to DONE on E0, so done is high in the cycle after E0.
  - Results: quotient=all ones, remainder=dividend, div_by_zero=1.
- Back-to-back: start=1 during the DONE cycle is accepted. The DONE→RUN transition must not lose the done pulse.
- Outputs are registered only. quotient, remainder and div_by_zero change only on a completion edge or on rst.
- rst asserted mid-RUN: abort on that edge, return to reset values, and produce no done pulse.
- Invariant for a nonzero divisor: dividend == quotient*divisor + remainder, with remainder < divisor.

Optional Feature:
- Macro SEQ_DIV_SIGNED_EN.
- Defined:
  - Adds input port signed_op (1 bit), captured on the accept edge.
  - When signed_op=1, operands are two's complement. The magnitudes are divided by the unsigned core.
  - Quotient is negated if the operand signs differ. Remainder takes the dividend's sign.
  - Sign fix-up is applied on the completion edge, so latency is unchanged.
  - Overflow case, -2^(size-1) / -1: quotient = -2^(size-1) (wraps), remainder=0, div_by_zero=0.
  - Signed divide by zero: quotient=all ones, remainder=dividend, div_by_zero=1.
- Undefined: no signed_op port; unsigned only. Behaviour is identical to the defined build with signed_op=0.

Test Plan:
- size=8, 100/7, start pulse → busy high 8 cycles; done in the 8th cycle after accept; quotient=14, remainder=2, div_by_zero=0.
- 255/1 → quotient=255, remainder=0. 3/10 → quotient=0, remainder=3. 200/200 → quotient=1, remainder=0.
- 5/0 → done in the cycle after accept, busy never high; quotient=0xFF, remainder=5, div_by_zero=1. A following 9/3 then clears div_by_zero: quotient=3, remainder=0.
- 100/7 accepted, then start held high with 9/3 during RUN → ignored, result still 14 r 2. Start with 9/3 during the DONE cycle → accepted; done again 8 cycles later with 3 r 0.
- rst asserted at iteration 4 of 100/7 → next cycle all outputs 0, state IDLE, no done pulse. A subsequent 100/7 completes normally.
- SEQ_DIV_SIGNED_EN, signed_op=1:
  - -7/2 → quotient=0xFD (-3), remainder=0xFF (-1).
  - 7/-2 → 0xFD, 1.
  - -128/-1 → quotient=0x80, remainder=0.
  - signed_op=0, 0xF9/2 → quotient=124, remainder=1.
